// File: rtl/jb_aes_key_expand.sv
// Iterative AES-128 key schedule.
// Streams round keys 0..10 one per cycle and keeps the round-10 key.
module jb_aes_key_expand #(
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 nStart,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 nDone,
    output logic                 busy,
    output logic                 rk_valid,
    output logic [3:0]           rk_index,
    output logic [KEY_WIDTH-1:0] round_key,
    output logic [KEY_WIDTH-1:0] final_key
);

    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    if (KEY_WIDTH != 128) begin : g_bad_width
        $error("jb_aes_key_expand: only KEY_WIDTH=128 is supported");
    end

    // S-box table, entry 0 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    state_t         state;
    state_t         state_n;
    logic           nDone_d;
    logic           busy_d;
    logic           rk_valid_d;
    logic [3:0]     rk_index_d;
    logic [127:0]   round_key_d;
    logic [127:0]   final_key_d;
    logic [7:0]     rcon;
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    t;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_key;

    // rcon for the round being produced, i.e. rk_index+1
    always_comb begin
        rcon = 8'h00;
        unique case (rk_index)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign t  = sub_word({w3[23:0], w3[31:24]})
              ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!nStart) state_n = EXPAND;
            EXPAND:  if (rk_index == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        nDone_d     = 1'b1;
        busy_d      = busy;
        rk_valid_d  = rk_valid;
        rk_index_d  = rk_index;
        round_key_d = round_key;
        final_key_d = final_key;
        unique case (state)
            IDLE: begin
                if (!nStart) begin
                    round_key_d = key;
                    rk_index_d  = 4'd0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            EXPAND: begin
                if (rk_index == LAST) begin
                    rk_valid_d = 1'b0;
                    nDone_d    = 1'b0;
                end else begin
                    round_key_d = next_key;
                    rk_index_d  = rk_index + 4'd1;
                    if (rk_index == LAST - 4'd1) begin
                        final_key_d = next_key;
                    end
                end
            end
            DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            nDone     <= 1'b1;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_index  <= 4'd0;
            round_key <= '0;
            final_key <= '0;
        end else begin
            nDone     <= nDone_d;
            busy      <= busy_d;
            rk_valid  <= rk_valid_d;
            rk_index  <= rk_index_d;
            round_key <= round_key_d;
            final_key <= final_key_d;
        end
    end

endmodule

// File: tb/tb_jb_aes_key_expand.sv
// Bench for jb_aes_key_expand: vector table, scoreboard of round keys.
// Reference S-box is derived from the GF(2^8) inverse plus affine map.
module tb_jb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         Rst = 1'b1;
    logic         nStart = 1'b1;
    logic [127:0] key = '0;
    logic         nDone;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic [127:0] final_key;

    jb_aes_key_expand dut (
        .clk       (clk),
        .Rst       (Rst),
        .nStart    (nStart),
        .key       (key),
        .nDone     (nDone),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_index  (rk_index),
        .round_key (round_key),
        .final_key (final_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        bit           has_ref;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    exp_t         sbq[$];
    exp_t         me;
    int           done_q[$];
    int           start_q[$];
    logic [127:0] seen [0:10];
    logic [7:0]   sb [256];
    int           nvalid = 0;
    int           cyc = 0;
    int           nvec = 0;
    int           nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rk_valid === 1'b1) begin
            nvalid++;
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_rk: got index %0d, none expected",
                         rk_index);
            end else begin
                me = sbq.pop_front();
                chk("rk_index", 128'(rk_index), 128'(me.idx));
                chk($sformatf("round_key[%0d]", me.idx), round_key, me.rk);
                if (rk_index <= 4'd10) seen[rk_index] = round_key;
                if (rk_index == 4'd0) start_q.push_back(cyc);
            end
        end
        if (nDone === 1'b0) done_q.push_back(cyc);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k,
                                                input int r);
        logic [7:0]  rc;
        logic [31:0] w [4];
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 1; i < r; i++)
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]],
             sb[w[3][31:24]]} ^ {rc, 24'h000000};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic push_run(input logic [127:0] k, output logic [127:0] rk10);
        exp_t         e;
        logic [127:0] w;
        w = k;
        e.idx = 4'd0;
        e.rk  = w;
        sbq.push_back(e);
        for (int r = 1; r <= 10; r++) begin
            w = model_next(w, r);
            e.idx = 4'(r);
            e.rk  = w;
            sbq.push_back(e);
        end
        rk10 = w;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_one(input string nm, input logic [127:0] k,
                           input int pa, input int pb, input bit has_ref,
                           input logic [127:0] r1, input logic [127:0] r10);
        logic [127:0] exp10;
        int           e;
        done_q.delete();
        start_q.delete();
        nvalid = 0;
        push_run(k, exp10);
        @(negedge clk);
        key = k;
        nStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e = cyc;
        nStart = 1'b1;
        key = rnd128();
        while (cyc < e + 13) begin
            @(negedge clk);
            key = rnd128();
            nStart = ((cyc - e) == pa - 1 || (cyc - e) == pb - 1) ? 1'b0 : 1'b1;
            if (cyc - e == 11) begin
                chk({nm, "_hold_rk"}, round_key, exp10);
                chk({nm, "_valid_low"}, 128'(rk_valid), 128'(0));
                chk({nm, "_busy_done"}, 128'(busy), 128'(1));
            end
        end
        nStart = 1'b1;
        chk({nm, "_busy_idle"}, 128'(busy), 128'(0));
        chk({nm, "_ndone_idle"}, 128'(nDone), 128'(1));
        chk({nm, "_final_key"}, final_key, exp10);
        chki({nm, "_valid_cycles"}, nvalid, 11);
        chki({nm, "_done_pulses"}, done_q.size(), 1);
        chki({nm, "_done_at"}, (done_q.size() > 0) ? done_q[0] - e : -1, 11);
        chki({nm, "_sb_left"}, sbq.size(), 0);
        if (has_ref) begin
            chk({nm, "_rk1_ref"}, seen[1], r1);
            chk({nm, "_rk10_ref"}, seen[10], r10);
            chk({nm, "_final_ref"}, final_key, r10);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt [4];
        logic [127:0] tmp;
        int           e;

        vt[0] = '{FIPS_KEY, 1'b1, FIPS_RK1, FIPS_RK10};
        vt[1] = '{128'h0, 1'b1,
                  128'h62636363626363636263636362636363,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vt[2] = '{rnd128(), 1'b0, 128'h0, 128'h0};
        vt[3] = '{rnd128(), 1'b0, 128'h0, 128'h0};

        build_sbox();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ndone", 128'(nDone), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_index", 128'(rk_index), 128'(0));
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_final_key", final_key, 128'h0);
        Rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run_one($sformatf("vec%0d", i), vt[i].key, -1, -1,
                    vt[i].has_ref, vt[i].rk1, vt[i].rk10);

        run_one("pulse", FIPS_KEY, 3, 11, 1'b1, FIPS_RK1, FIPS_RK10);
        repeat (3) @(negedge clk);
        chk("pulse_no_restart", 128'(busy), 128'(0));

        sbq.delete();
        push_run(FIPS_KEY, tmp);
        @(negedge clk);
        key = FIPS_KEY;
        nStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e = cyc;
        nStart = 1'b1;
        while (cyc < e + 4) @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        chk("midrst_ndone", 128'(nDone), 128'(1));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(rk_valid), 128'(0));
        chk("midrst_index", 128'(rk_index), 128'(0));
        chk("midrst_round_key", round_key, 128'h0);
        chk("midrst_final_key", final_key, 128'h0);
        Rst = 1'b0;
        sbq.delete();
        run_one("after_rst", FIPS_KEY, -1, -1, 1'b1, FIPS_RK1, FIPS_RK10);

        done_q.delete();
        start_q.delete();
        sbq.delete();
        push_run(FIPS_KEY, tmp);
        push_run(FIPS_KEY, tmp);
        @(negedge clk);
        key = FIPS_KEY;
        nStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e = cyc;
        while (cyc < e + 25) @(negedge clk);
        nStart = 1'b1;
        while (cyc < e + 29) @(negedge clk);
        chki("b2b_starts", start_q.size(), 2);
        chki("b2b_start_gap",
             (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 13);
        chki("b2b_done_pulses", done_q.size(), 2);
        chki("b2b_done0", (done_q.size() > 0) ? done_q[0] - e : -1, 11);
        chki("b2b_done1", (done_q.size() > 1) ? done_q[1] - e : -1, 24);
        chki("b2b_sb_left", sbq.size(), 0);
        chk("b2b_final_key", final_key, FIPS_RK10);
        chk("b2b_busy_idle", 128'(busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
